// File: rtl/prbs_checker.sv
// ============================================================================
// Module   : prbs_checker
// Purpose  : Receive-side checker for the 8-bit LFSR stimulus stream. Locks
//            onto an incoming LFSR word stream, predicts every next word,
//            reports lock status and counts prediction mismatches.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   STEPS     LFSR single-steps per valid word (matches the generator)
//   LOCK_CNT  consecutive matches in LOCKING needed to enter LOCKED
//   LOSS_CNT  consecutive mismatches in LOCKED that drop lock
//   CW        width of err_cnt
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   in_valid   in   in_data is sampled on this clock edge
//   in_data    in   received LFSR word [7:0]
//   clear_err  in   synchronous clear of err_cnt
//   locked     out  high while state == LOCKED
//   state      out  0=SEARCH 1=LOCKING 2=LOCKED
//   err_cnt    out  saturating mismatch count [CW-1:0]
//   err_pulse  out  one-cycle strobe per counted mismatch
//   sig        out  MISR signature of the received stream [7:0]
//                   (present only when PRBS_CHK_SIG_EN is defined)
// Build option:
//   PRBS_CHK_SIG_EN  adds the sig output and its signature register
// ============================================================================
`default_nettype none

module prbs_checker #(
  parameter int STEPS    = 3,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int CW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  input  logic          clear_err,
  output logic          locked,
  output logic [1:0]    state,
  output logic [CW-1:0] err_cnt,
  output logic          err_pulse
`ifdef PRBS_CHK_SIG_EN
  ,
  output logic [7:0]    sig
`endif
);

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_LOCKING = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  // The run counter holds either a match run (LOCKING) or a miss run (LOCKED).
  localparam int RUN_MAX = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
  localparam int RW      = (RUN_MAX < 1) ? 1 : $clog2(RUN_MAX + 1);
  localparam logic [RW-1:0] RUN_LOCK = RW'(LOCK_CNT);
  localparam logic [RW-1:0] RUN_LOSS = RW'(LOSS_CNT);

  function automatic logic [7:0] step1(input logic [7:0] r);
    return {r[6:0], r[3] ^ r[4] ^ r[5] ^ r[7]};
  endfunction

  function automatic logic [7:0] adv(input logic [7:0] x);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < STEPS; i++) begin
      r = step1(r);
    end
    return r;
  endfunction

  logic [1:0]    state_q,     state_d;
  logic          locked_q,    locked_d;
  logic [7:0]    exp_q,       exp_d;
  logic [RW-1:0] run_q,       run_d;
  logic [CW-1:0] err_cnt_q,   err_cnt_d;
  logic          err_pulse_q, err_pulse_d;

  logic [7:0]    adv_in;
  logic [7:0]    adv_exp;
  logic [RW-1:0] run_inc;
  logic          match;

  assign adv_in  = adv(in_data);
  assign adv_exp = adv(exp_q);
  assign run_inc = run_q + 1'b1;
  assign match   = (in_data == exp_q);

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    run_d       = run_q;
    err_cnt_d   = err_cnt_q;
    err_pulse_d = 1'b0;

    if (in_valid) begin
      case (state_q)
        ST_SEARCH: begin
          // 0x00 is the LFSR lock-up value and can never seed a valid stream.
          if (in_data != 8'h00) begin
            exp_d   = adv_in;
            run_d   = '0;
            state_d = ST_LOCKING;
          end
        end
        ST_LOCKING: begin
          if (match) begin
            exp_d = adv_exp;
            if (run_inc == RUN_LOCK) begin
              state_d = ST_LOCKED;
              run_d   = '0;
            end else begin
              run_d = run_inc;
            end
          end else if (in_data == 8'h00) begin
            state_d = ST_SEARCH;
            run_d   = '0;
          end else begin
            exp_d = adv_in;
            run_d = '0;
          end
        end
        ST_LOCKED: begin
          // Flywheel: the prediction always advances on its own, so a
          // corrupted word can never pull the checker off the sequence.
          exp_d = adv_exp;
          if (match) begin
            run_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != {CW{1'b1}}) begin
              err_cnt_d = err_cnt_q + 1'b1;
            end
            if (run_inc == RUN_LOSS) begin
              state_d = ST_SEARCH;
              run_d   = '0;
            end else begin
              run_d = run_inc;
            end
          end
        end
        default: begin
          state_d = ST_SEARCH;
          run_d   = '0;
        end
      endcase
    end

    // Clear takes priority over a simultaneous counted mismatch.
    if (clear_err) begin
      err_cnt_d = '0;
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SEARCH;
      locked_q    <= 1'b0;
      exp_q       <= 8'h00;
      run_q       <= '0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      locked_q    <= locked_d;
      exp_q       <= exp_d;
      run_q       <= run_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign state     = state_q;
  assign locked    = locked_q;
  assign err_cnt   = err_cnt_q;
  assign err_pulse = err_pulse_q;

`ifdef PRBS_CHK_SIG_EN
  // MISR over every valid word regardless of lock state.
  logic [7:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (in_valid) begin
      sig_d = step1(sig_q) ^ in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= 8'h00;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;
`endif

endmodule

`default_nettype wire
